// File: rtl/ctrl_pkg.sv
// Shared encodings for ctrl_seq: FSM states, endpoint IDs, bus op codes and completion status.
// Also holds the req_data field offsets, expressed as functions of ADDRW/IDW.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RDKEY,
    ST_W_RDKEY,
    ST_RDTEXT,
    ST_W_RDTEXT,
    ST_OP,
    ST_W_OP,
    ST_MEMWR,
    ST_W_MEMWR,
    ST_CPL
  } state_e;

  localparam int MEM_ID = 0;

  localparam logic [1:0] OPC_RDKEY  = 2'b00;
  localparam logic [1:0] OPC_RDTEXT = 2'b01;
  localparam logic [1:0] OPC_OP     = 2'b11;
  localparam logic [1:0] OPC_MEMWR  = 2'b10;

  localparam logic [1:0] STS_OK      = 2'b00;
  localparam logic [1:0] STS_BAD_ID  = 2'b01;
  localparam logic [1:0] STS_TIMEOUT = 2'b10;

  // req_data layout, LSB first: dest, text, key, accel_id, mode, key_reuse
  function automatic int text_lsb(input int addrw);
    return addrw;
  endfunction

  function automatic int key_lsb(input int addrw);
    return 2 * addrw;
  endfunction

  function automatic int id_lsb(input int addrw);
    return 3 * addrw;
  endfunction

  function automatic int mode_bit(input int addrw, input int idw);
    return 3 * addrw + idw;
  endfunction

  function automatic int reuse_bit(input int addrw, input int idw);
    return 3 * addrw + idw + 1;
  endfunction

endpackage

// File: rtl/ctrl_ack_timer.sv
// Wait-state cycle counter: expired is high once TIMEOUT_CYC-1 cycles have been counted since clr.
// Exists only in CTRL_SEQ_TIMEOUT_EN builds; the default build carries no timer logic at all.
`ifdef CTRL_SEQ_TIMEOUT_EN
module ctrl_ack_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/ctrl_seq.sv
// Crypto request sequencer: one request in flight, key/text read, accel op, result write, completion.
// Moore outputs; waits indefinitely on grant/ack/compq_ready unless CTRL_SEQ_TIMEOUT_EN bounds ack waits.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int ADDRW       = 24,
  parameter int IDW         = 2,
  parameter int NUM_ACCEL   = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic [3*ADDRW+IDW+2-1:0]   req_data,
  output logic                       req_ready,
  output logic                       arb_req,
  input  logic                       arb_grant,
  input  logic [IDW:0]               ack_in,
  output logic [ADDRW+4+2*IDW-1:0]   data_out,
  input  logic                       compq_ready,
  output logic                       compq_valid,
  output logic [ADDRW+2-1:0]         compq_data
);

  localparam int REQW      = 3 * ADDRW + IDW + 2;
  localparam int CAPW      = REQW - 1;
  localparam int TEXT_LSB  = text_lsb(ADDRW);
  localparam int KEY_LSB   = key_lsb(ADDRW);
  localparam int ID_LSB    = id_lsb(ADDRW);
  localparam int MODE_BIT  = mode_bit(ADDRW, IDW);
  localparam int REUSE_BIT = reuse_bit(ADDRW, IDW);

  localparam logic [IDW-1:0] MEM_IDV = IDW'(MEM_ID);
  localparam logic [IDW-1:0] MAX_ID  = IDW'(NUM_ACCEL);

  state_e            state_q, state_d;
  // key_reuse only steers the IDLE decision, so it is not kept
  logic [CAPW-1:0]   cap_q, cap_d;
  logic [1:0]        status_q, status_d;

  logic [ADDRW-1:0]  dest_w, text_w, key_w;
  logic [IDW-1:0]    id_w, new_id;
  logic              mode_w, new_reuse;
  logic              mem_ack, acc_ack, ack_hit, is_req_st;

  assign dest_w    = cap_q[ADDRW-1:0];
  assign text_w    = cap_q[TEXT_LSB +: ADDRW];
  assign key_w     = cap_q[KEY_LSB +: ADDRW];
  assign id_w      = cap_q[ID_LSB +: IDW];
  assign mode_w    = cap_q[MODE_BIT];
  assign new_id    = req_data[ID_LSB +: IDW];
  assign new_reuse = req_data[REUSE_BIT];

  assign mem_ack   = (ack_in == {1'b1, MEM_IDV});
  assign acc_ack   = (ack_in == {1'b1, id_w});
  assign ack_hit   = (state_q == ST_W_OP) ? acc_ack : mem_ack;
  assign is_req_st = (state_q == ST_RDKEY) || (state_q == ST_RDTEXT) ||
                     (state_q == ST_OP)    || (state_q == ST_MEMWR);

`ifdef CTRL_SEQ_TIMEOUT_EN
  logic tmr_clr, tmr_en, tmr_exp, is_wait_st;

  assign is_wait_st = (state_q == ST_W_RDKEY) || (state_q == ST_W_RDTEXT) ||
                      (state_q == ST_W_OP)    || (state_q == ST_W_MEMWR);
  assign tmr_clr    = is_req_st && arb_grant;
  assign tmr_en     = is_wait_st;

  ctrl_ack_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_ack_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_exp)
  );
`endif

  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    status_d = status_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cap_d    = req_data[CAPW-1:0];
          status_d = STS_OK;
          if (new_id == '0 || new_id > MAX_ID) begin
            state_d  = ST_CPL;
            status_d = STS_BAD_ID;
          end else if (new_reuse) begin
            state_d = ST_RDTEXT;
          end else begin
            state_d = ST_RDKEY;
          end
        end
      end
      ST_RDKEY:    if (arb_grant) state_d = ST_W_RDKEY;
      ST_RDTEXT:   if (arb_grant) state_d = ST_W_RDTEXT;
      ST_OP:       if (arb_grant) state_d = ST_W_OP;
      ST_MEMWR:    if (arb_grant) state_d = ST_W_MEMWR;
      ST_W_RDKEY:  if (ack_hit) state_d = ST_RDTEXT;
      ST_W_RDTEXT: if (ack_hit) state_d = ST_OP;
      ST_W_OP:     if (ack_hit) state_d = ST_MEMWR;
      ST_W_MEMWR:  if (ack_hit) state_d = ST_CPL;
      ST_CPL:      if (compq_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
`ifdef CTRL_SEQ_TIMEOUT_EN
    // a matching ack in the expiry cycle takes priority over the timeout
    if (is_wait_st && !ack_hit && tmr_exp) begin
      state_d  = ST_CPL;
      status_d = STS_TIMEOUT;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cap_q    <= '0;
      status_q <= STS_OK;
    end else begin
      state_q  <= state_d;
      cap_q    <= cap_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    req_ready   = 1'b0;
    arb_req     = 1'b0;
    data_out    = '0;
    compq_valid = 1'b0;
    compq_data  = '0;
    if (!rst) begin
      arb_req = is_req_st;
      unique case (state_q)
        ST_IDLE:                 req_ready = 1'b1;
        ST_RDKEY, ST_W_RDKEY:    data_out = {key_w, 1'b0, mode_w, id_w, MEM_IDV, OPC_RDKEY};
        ST_RDTEXT, ST_W_RDTEXT:  data_out = {text_w, 1'b0, mode_w, id_w, MEM_IDV, OPC_RDTEXT};
        ST_OP, ST_W_OP:          data_out = {{ADDRW{1'b0}}, 1'b0, mode_w, id_w, id_w, OPC_OP};
        ST_MEMWR, ST_W_MEMWR:    data_out = {dest_w, 1'b0, mode_w, MEM_IDV, id_w, OPC_MEMWR};
        ST_CPL: begin
          compq_valid = 1'b1;
          compq_data  = {status_q, dest_w};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: scoreboard queues of expected bus commands and completion entries.
module tb_ctrl_seq;

  localparam int ADDRW       = 24;
  localparam int IDW         = 2;
  localparam int NUM_ACCEL   = 3;
  localparam int TIMEOUT_CYC = 16;
  localparam int REQW        = 3 * ADDRW + IDW + 2;
  localparam int DOW         = ADDRW + 4 + 2 * IDW;
  localparam int CQW         = ADDRW + 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic [REQW-1:0] req_data = '0;
  logic            arb_grant = 1'b0;
  logic [IDW:0]    ack_in = '0;
  logic            compq_ready = 1'b0;
  logic            req_ready, arb_req, compq_valid;
  logic [DOW-1:0]  data_out;
  logic [CQW-1:0]  compq_data;

  int compared = 0;
  int mismatched = 0;
  int hs_cnt = 0;

  logic [DOW-1:0] cmd_q[$];
  logic [CQW-1:0] cpl_q[$];

  ctrl_seq #(
    .ADDRW       (ADDRW),
    .IDW         (IDW),
    .NUM_ACCEL   (NUM_ACCEL),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .arb_req     (arb_req),
    .arb_grant   (arb_grant),
    .ack_in      (ack_in),
    .data_out    (data_out),
    .compq_ready (compq_ready),
    .compq_valid (compq_valid),
    .compq_data  (compq_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && req_valid && req_ready) hs_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DOW-1:0] mk_cmd(input logic [ADDRW-1:0] a, input logic m,
                                            input logic [IDW-1:0] s, input logic [IDW-1:0] d,
                                            input logic [1:0] op);
    return {a, 1'b0, m, s, d, op};
  endfunction

  task automatic send_req(input logic [ADDRW-1:0] key, input logic [ADDRW-1:0] text,
                          input logic [ADDRW-1:0] dest, input logic [IDW-1:0] id,
                          input logic mode, input logic reuse);
    int n;
    if (id == '0 || int'(id) > NUM_ACCEL) begin
      cpl_q.push_back({2'b01, dest});
    end else begin
      if (!reuse) cmd_q.push_back(mk_cmd(key, mode, id, '0, 2'b00));
      cmd_q.push_back(mk_cmd(text, mode, id, '0, 2'b01));
      cmd_q.push_back(mk_cmd('0, mode, id, id, 2'b11));
      cmd_q.push_back(mk_cmd(dest, mode, '0, id, 2'b10));
      cpl_q.push_back({2'b00, dest});
    end
    req_data  = {reuse, mode, id, key, text, dest};
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("req_ready_wait", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  // Serves bus grants/acks and the completion handshake until one completion is accepted.
  task automatic run_txn(input int gdly, input int cdly, input bit wrong_acks);
    logic [DOW-1:0] e_cmd;
    logic [CQW-1:0] e_cpl;
    logic [IDW-1:0] aid;
    bit done;
    int budget;
    done = 0;
    budget = 400;
    while (!done && budget > 0) begin
      budget--;
      if (compq_valid === 1'b1) begin
        done = 1;
        if (cpl_q.size() == 0) begin
          chk("unexpected_cpl", compq_valid, 0);
        end else begin
          e_cpl = cpl_q.pop_front();
          for (int i = 0; i < cdly; i++) begin
            chk("cpl_hold_vld", compq_valid, 1);
            chk("cpl_hold_dat", compq_data, e_cpl);
            chk("cpl_req_ready_low", req_ready, 0);
            tick();
          end
          chk("cpl_dat", compq_data, e_cpl);
          chk("cpl_cmds_left", cmd_q.size(), 0);
          compq_ready = 1'b1;
          tick();
          compq_ready = 1'b0;
          chk("idle_after_cpl", {req_ready, compq_valid, arb_req}, 3'b100);
        end
      end else if (arb_req === 1'b1) begin
        if (cmd_q.size() == 0) begin
          chk("unexpected_arb_req", arb_req, 0);
          done = 1;
        end else begin
          e_cmd = cmd_q.pop_front();
          aid = (e_cmd[1:0] == 2'b11) ? e_cmd[IDW+1:2] : '0;
          for (int i = 0; i < gdly; i++) begin
            chk("arb_hold_req", arb_req, 1);
            chk("arb_hold_dat", data_out, e_cmd);
            tick();
          end
          chk("cmd", data_out, e_cmd);
          arb_grant = 1'b1;
          tick();
          arb_grant = 1'b0;
          chk("wait_arb_drop", arb_req, 0);
          tick();
          chk("wait_hold_dat", {arb_req, compq_valid, data_out}, {2'b00, e_cmd});
          if (wrong_acks) begin
            for (int j = 0; j < (1 << IDW); j++) begin
              if (j != int'(aid)) begin
                ack_in = {1'b1, IDW'(j)};
                tick();
                chk("wrong_ack_hold", {arb_req, compq_valid, data_out}, {2'b00, e_cmd});
              end
            end
          end
          ack_in = {1'b1, aid};
          tick();
          ack_in = '0;
        end
      end else begin
        tick();
      end
    end
    if (!done) chk("txn_done", done, 1);
  endtask

  initial begin
    logic [DOW-1:0] e;
    int hs0;
    int n;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_outputs", {req_ready, arb_req, compq_valid, data_out, compq_data}, '0);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", {req_ready, arb_req, compq_valid, data_out, compq_data},
        {1'b1, {(2 + DOW + CQW){1'b0}}});

    // full flow, immediate grants
    hs0 = hs_cnt;
    send_req(24'h000100, 24'h000200, 24'h000300, 2'd3, 1'b1, 1'b0);
    chk("full_hs_once", hs_cnt, hs0 + 1);
    run_txn(0, 0, 0);
    chk("full_hs_total", hs_cnt, hs0 + 1);

    // key reuse: first command is the text read
    send_req(24'h000111, 24'h000222, 24'h000333, 2'd1, 1'b0, 1'b1);
    chk("reuse_first_cmd", {arb_req, data_out}, {1'b1, mk_cmd(24'h000222, 1'b0, 2'd1, 2'd0, 2'b01)});
    run_txn(0, 0, 0);

    // accel_id 0 is rejected without bus activity
    send_req(24'h000AAA, 24'h000BBB, 24'h000444, 2'd0, 1'b1, 1'b0);
    chk("bad_id_no_arb", arb_req, 0);
    run_txn(0, 0, 0);

    // wrong-ID acks ignored in every wait state, grants delayed 5 cycles
    send_req(24'h001000, 24'h002000, 24'h003000, 2'd2, 1'b1, 1'b0);
    run_txn(5, 0, 1);

    // completion stalled 10 cycles with a pending request that must wait for IDLE
    send_req(24'h00C001, 24'h00C002, 24'h00C003, 2'd3, 1'b0, 1'b0);
    req_data  = {1'b0, 1'b0, 2'd0, 24'h0, 24'h0, 24'h000777};
    req_valid = 1'b1;
    hs0 = hs_cnt;
    run_txn(0, 10, 0);
    chk("stall_no_capture", hs_cnt, hs0);
    send_req(24'h0, 24'h0, 24'h000777, 2'd0, 1'b0, 1'b0);
    chk("stall_capture_once", hs_cnt, hs0 + 1);
    run_txn(0, 0, 0);

    // reset in W_RDTEXT abandons the request
    send_req(24'h000500, 24'h000600, 24'h000700, 2'd1, 1'b0, 1'b0);
    e = cmd_q.pop_front();
    chk("rstmid_rdkey", data_out, e);
    arb_grant = 1'b1;
    tick();
    arb_grant = 1'b0;
    ack_in = {1'b1, 2'd0};
    tick();
    ack_in = '0;
    e = cmd_q.pop_front();
    chk("rstmid_rdtext", {arb_req, data_out}, {1'b1, e});
    arb_grant = 1'b1;
    tick();
    arb_grant = 1'b0;
    chk("rstmid_w_rdtext", {arb_req, data_out}, {1'b0, e});
    rst = 1'b1;
    #1;
    chk("rstmid_outs_during", {req_ready, arb_req, compq_valid, data_out, compq_data}, '0);
    tick();
    chk("rstmid_outs_after", {req_ready, arb_req, compq_valid, data_out, compq_data}, '0);
    rst = 1'b0;
    tick();
    chk("rstmid_idle", {req_ready, arb_req, compq_valid}, 3'b100);
    repeat (5) begin
      ack_in = {1'b1, 2'd0};
      tick();
      chk("rstmid_no_cpl", {arb_req, compq_valid}, 2'b00);
    end
    ack_in = '0;
    cmd_q.delete();
    cpl_q.delete();

    // recovery after reset
    send_req(24'h00F100, 24'h00F200, 24'h00F300, 2'd1, 1'b1, 1'b0);
    run_txn(1, 2, 0);

`ifdef CTRL_SEQ_TIMEOUT_EN
    // no ack: timeout after exactly TIMEOUT_CYC wait cycles
    send_req(24'h000010, 24'h000020, 24'h000030, 2'd1, 1'b0, 1'b0);
    e = cmd_q.pop_front();
    chk("tmo_rdkey", data_out, e);
    arb_grant = 1'b1;
    tick();
    arb_grant = 1'b0;
    n = 0;
    while (compq_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_wait_cycles", n, TIMEOUT_CYC);
    chk("tmo_status", compq_data, {2'b10, 24'h000030});
    compq_ready = 1'b1;
    tick();
    compq_ready = 1'b0;
    cmd_q.delete();
    cpl_q.delete();

    // ack in the expiry cycle continues normally
    send_req(24'h000040, 24'h000050, 24'h000060, 2'd2, 1'b1, 1'b0);
    e = cmd_q.pop_front();
    chk("tmo2_rdkey", data_out, e);
    arb_grant = 1'b1;
    tick();
    arb_grant = 1'b0;
    repeat (TIMEOUT_CYC - 1) tick();
    chk("tmo2_still_wait", {arb_req, compq_valid, data_out}, {2'b00, e});
    ack_in = {1'b1, 2'd0};
    tick();
    ack_in = '0;
    chk("tmo2_advance", {arb_req, data_out}, {1'b1, cmd_q[0]});
    run_txn(0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Parametrised successor to the single-accelerator control FSM.
- Dequeues one crypto request, then sequences it on the shared bus: key read (skippable), text read, accelerator op, result write.
- Selects the target accelerator per request and reports a status code to the completion queue.
- Sits between the request queue, the bus arbiter/data bus, and the completion queue.

Parameters:
- ADDRW, 24, address width of key/text/dest fields.
- IDW, 2, bus endpoint ID width; MEM_ID is fixed at 0.
- NUM_ACCEL, 3, number of valid accelerator IDs (1..NUM_ACCEL); must be < 2**IDW.
- TIMEOUT_CYC, 1024, ack wait limit in cycles (used only with CTRL_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request available
- req_data  in  3*ADDRW+IDW+2  request word. Fields: [ADDRW-1:0] dest, [2ADDRW-1:ADDRW] text, [3ADDRW-1:2ADDRW] key, next IDW bits accel_id, then mode bit, then key_reuse bit (MSB).
- req_ready  out  1  dequeue strobe to request queue
- arb_req  out  1  bus request
- arb_grant  in  1  bus grant
- ack_in  in  IDW+1  {ack_valid, source_id}
- data_out  out  ADDRW+4+2*IDW  {addr, 1'b0, mode, src_id, dst_id, op[1:0]}; op is 00 RDKEY, 01 RDTEXT, 11 OP, 10 MEMWR.
- compq_ready  in  1  completion queue can accept
- compq_valid  out  1  completion entry valid
- compq_data  out  ADDRW+2  {status[1:0], dest addr}; status is 00 OK, 01 BAD_ID, 10 TIMEOUT.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high, sampled on posedge clk. It forces state to IDLE and clears the capture register and timer. Reset mid-operation abandons the request with no completion entry.
- Reset output values: all outputs are 0, including req_ready while rst is high.
- Output style: outputs are Moore-decoded from state plus capture register only. There are no combinational input-to-output paths.
- States: IDLE, RDKEY, W_RDKEY, RDTEXT, W_RDTEXT, OP, W_OP, MEMWR, W_MEMWR, CPL.
- IDLE:
  - req_ready=1.
  - On req_valid, capture req_data and clear status.
  - If accel_id==0 or accel_id>NUM_ACCEL, go to CPL with status 01 and no bus activity.
  - Otherwise, if key_reuse=1 go to RDTEXT, else go to RDKEY.
- Request states (RDKEY, RDTEXT, OP, MEMWR):
  - arb_req=1, and data_out carries the command.
  - A grant sampled high advances to the matching W_ state. Grant in the first cycle of the state counts (minimum 1 cycle per request state).
  - arb_req drops in the W_ state.
- Commands:
  - RDKEY and RDTEXT: src=accel_id, dst=MEM_ID, addr=key/text.
  - OP: addr=0, src=accel_id, dst=accel_id, mode bit carried.
  - MEMWR: addr=dest, src=MEM_ID, dst=accel_id.
- Wait states (W_ states):
  - data_out is held at the same value.
  - W_RDKEY, W_RDTEXT and W_MEMWR advance only on ack_in=={1,MEM_ID}.
  - W_OP advances only on ack_in=={1,accel_id}.
  - Acks with another ID, or acks arriving in non-wait states, are ignored (not stored).
- Transitions: W_RDKEY→RDTEXT, W_RDTEXT→OP, W_OP→MEMWR, W_MEMWR→CPL.
- CPL:
  - compq_valid=1; compq_data is stable until accepted.
  - compq_ready high moves to IDLE in the same edge.
  - req_ready stays 0 until the state is IDLE again, giving at most one request in flight.
- Simultaneous events:
  - rst wins over all other inputs.
  - In CPL, compq_ready with req_valid high: the new request is not captured until the IDLE cycle.

Optional Feature:
- CTRL_SEQ_TIMEOUT_EN defined:
  - A cycle counter clears on entry to each W_ state and counts while waiting.
  - When it reaches TIMEOUT_CYC-1 without a matching ack, the block goes to CPL with status 10.
  - A matching ack in the expiry cycle wins (status 00 path).
- Not defined: no counter logic. W_ states wait indefinitely, and status 10 is never produced.

Decomposition:
- ctrl_pkg holds:
  - the state encoding;
  - MEM_ID;
  - op codes RDKEY/RDTEXT/OP/MEMWR;
  - status codes OK/BAD_ID/TIMEOUT;
  - req_data field offset functions of ADDRW/IDW.
- One sub-module, ctrl_ack_timer (clear, enable, expired; width $clog2(TIMEOUT_CYC)). It is instantiated only under CTRL_SEQ_TIMEOUT_EN.

Test Plan:
- Full flow: key=0x000100, text=0x000200, dest=0x000300, id=3, mode=1, reuse=0, with immediate grants and correct acks. Expect data_out commands in order RDKEY/RDTEXT/OP/MEMWR, then compq_data={00,0x000300}. req_ready pulses once.
- key_reuse=1: no RDKEY command ever appears, first arb_req carries op=01 addr=text, and completion status is 00.
- accel_id=0, then accel_id=NUM_ACCEL+1 (if representable): arb_req stays 0, and CPL reports status 01 with the dest addr.
- Wrong-ID ack: in W_OP with id=2, drive ack {1,0} then {1,1}. State holds. Ack {1,2} advances to MEMWR. Grant delayed 5 cycles keeps arb_req and data_out stable.
- compq_ready held low 10 cycles: compq_valid and compq_data stay stable, and req_valid is ignored. Also assert rst mid-W_RDTEXT: the next cycle shows IDLE, all outputs 0, and no completion entry.
- CTRL_SEQ_TIMEOUT_EN with TIMEOUT_CYC=16: no ack in W_RDKEY gives status 10 after exactly 16 wait cycles. An ack on cycle 16 gives a normal path.
